// File: rtl/acfg_pkg.sv
// acfg_pkg: shared definitions for the Zorro II AutoConfig responder.
//   - AutoConfig register offsets, expressed as A[7:1] word indices
//   - DTACK sequencer state encoding
//   - size-code to address-mask helper used by the board decoders
package acfg_pkg;

    // Word indices (A[7:1]) of the AutoConfig registers. The byte offset
    // seen by software is twice the index (e.g. 7'h24 -> $E80048).
    localparam logic [6:0] ER_TYPE_OFS    = 7'h00;  // $00/$02
    localparam logic [6:0] ER_PRODUCT_OFS = 7'h02;  // $04/$06
    localparam logic [6:0] ER_FLAGS_OFS   = 7'h04;  // $08/$0A
    localparam logic [6:0] MFR_OFS        = 7'h08;  // $10..$16, two bytes
    localparam logic [6:0] SERIAL_OFS     = 7'h0C;  // $18..$26, four bytes
    localparam logic [6:0] BASE_HI_OFS    = 7'h24;  // $48 write: A[23:20], commits
    localparam logic [6:0] BASE_LO_OFS    = 7'h25;  // $4A write: A[19:16]
    localparam logic [6:0] SHUTUP_OFS     = 7'h26;  // $4C write: shut up board

    // A[23:16] of the AutoConfig space ($E80000).
    localparam logic [7:0] AC_SPACE = 8'hE8;

    typedef enum logic [1:0] {
        DT_IDLE = 2'd0,
        DT_WAIT = 2'd1,
        DT_ACK  = 2'd2
    } dtack_state_t;

    // Which A[23:16] bits take part in the base compare for a Zorro II size
    // code. Code 000 is 8 MB, so only A[23] distinguishes the window.
    function automatic logic [7:0] size_mask(input logic [2:0] code);
        logic [7:0] mask;
        case (code)
            3'b001:  mask = 8'hFF;  // 64 KB
            3'b010:  mask = 8'hFE;  // 128 KB
            3'b011:  mask = 8'hFC;  // 256 KB
            3'b100:  mask = 8'hF8;  // 512 KB
            3'b101:  mask = 8'hF0;  // 1 MB
            3'b110:  mask = 8'hE0;  // 2 MB
            3'b111:  mask = 8'hC0;  // 4 MB
            default: mask = 8'h80;  // 8 MB
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/acfg_nibble_rom.sv
// acfg_nibble_rom: combinational AutoConfig register file for one selected
// board. Returns the nibble software reads at A[7:1] for board board_sel.
//   Byte n = index[6:1]; index[0] = 0 gives the high nibble, 1 the low one.
//   er_Type is presented true, every other defined byte inverted, and
//   undefined locations read as 4'hF.
// Ports:
//   board_sel  in  2  index of the board being presented (0 = first in chain)
//   index      in  7  A[7:1]
//   nibble     out 4  value for D[15:12]
// Parameter lists are packed with board 0 in the most significant byte.
module acfg_nibble_rom
    import acfg_pkg::*;
#(
    parameter int                      NUM_BOARDS   = 3,
    parameter logic [8*NUM_BOARDS-1:0] ER_TYPE      = {8'hE5, 8'hC4, 8'hC1},
    parameter logic [8*NUM_BOARDS-1:0] ER_PRODUCT   = {8'h9F, 8'h9E, 8'h9D},
    parameter logic [7:0]              ER_FLAGS     = 8'h80,
    parameter logic [15:0]             MANUFACTURER = 16'h07DB,
    parameter logic [31:0]             SERIAL       = 32'h1BEA5CC0
) (
    input  logic [1:0] board_sel,
    input  logic [6:0] index,
    output logic [3:0] nibble
);

    logic [7:0] type_b;
    logic [7:0] prod_b;
    logic [7:0] byte_v;
    logic       defined;
    logic [5:0] byte_n;
    logic [3:0] raw;

    assign byte_n = index[6:1];

    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        type_b = 8'h00;
        prod_b = 8'h00;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (board_sel == 2'(i)) begin
                type_b = ER_TYPE[8*(NUM_BOARDS-1-i) +: 8];
                prod_b = ER_PRODUCT[8*(NUM_BOARDS-1-i) +: 8];
            end
        end
    end

    always_comb begin
        byte_v  = 8'hFF;
        defined = 1'b1;
        if      (byte_n == ER_TYPE_OFS[6:1])          byte_v = type_b;
        else if (byte_n == ER_PRODUCT_OFS[6:1])       byte_v = prod_b;
        else if (byte_n == ER_FLAGS_OFS[6:1])         byte_v = ER_FLAGS;
        else if (byte_n == MFR_OFS[6:1])              byte_v = MANUFACTURER[15:8];
        else if (byte_n == MFR_OFS[6:1] + 6'd1)       byte_v = MANUFACTURER[7:0];
        else if (byte_n == SERIAL_OFS[6:1])           byte_v = SERIAL[31:24];
        else if (byte_n == SERIAL_OFS[6:1] + 6'd1)    byte_v = SERIAL[23:16];
        else if (byte_n == SERIAL_OFS[6:1] + 6'd2)    byte_v = SERIAL[15:8];
        else if (byte_n == SERIAL_OFS[6:1] + 6'd3)    byte_v = SERIAL[7:0];
        else                                          defined = 1'b0;
    end

    assign raw = index[0] ? byte_v[3:0] : byte_v[7:4];

    // er_Type is the only register the Zorro II protocol reads non-inverted.
    always_comb begin
        if (!defined)
            nibble = 4'hF;
        else if (byte_n == ER_TYPE_OFS[6:1])
            nibble = raw;
        else
            nibble = ~raw;
    end

endmodule

// File: rtl/autoconfig_chain.sv
// autoconfig_chain: CPU_CLK-synchronous Zorro II AutoConfig responder for a
// chain of NUM_BOARDS logical boards at $E80000, plus per-board address
// decode for the chip-select logic downstream.
// Optional feature (define AUTOCONFIG_REREAD_EN): writing 4'hA to $E8007E
// clears all CONFIGURED/SHUTUP bits, even after the chain has closed, so
// diagnostic tools can re-enumerate without a reset.
// Ports:
//   CPU_CLK           in   1   clock, all state on the rising edge
//   RESET             in   1   asynchronous reset, active low
//   CPU_AS            in   1   /AS
//   UDS, LDS          in   1   /UDS, /LDS
//   RW                in   1   1 = read
//   ADDRESS           in   23  A[23:1]
//   DATA_IN           in   4   D[15:12] on writes
//   AC_DATA_OUT       out  4   registered read nibble for D[15:12]
//   AC_DATA_OE        out  1   drive enable for D[15:12]
//   AC_DTACK          out  1   /DTACK for AutoConfig cycles
//   AC_OPEN           out  1   some board is still unconfigured and not shut up
//   BOARD_BASE        out  8*N A[23:16] assigned to board i, in [8*i +: 8]
//   BOARD_CONFIGURED  out  N   base committed
//   BOARD_SHUTUP      out  N   board shut up
//   BOARD_MATCH       out  N   bus cycle hits board i's configured window
module autoconfig_chain
    import acfg_pkg::*;
#(
    parameter int                      NUM_BOARDS   = 3,
    parameter logic [8*NUM_BOARDS-1:0] ER_TYPE      = {8'hE5, 8'hC4, 8'hC1},
    parameter logic [8*NUM_BOARDS-1:0] ER_PRODUCT   = {8'h9F, 8'h9E, 8'h9D},
    parameter logic [7:0]              ER_FLAGS     = 8'h80,
    parameter logic [15:0]             MANUFACTURER = 16'h07DB,
    parameter logic [31:0]             SERIAL       = 32'h1BEA5CC0,
    parameter int                      DTACK_WAIT   = 2
) (
    input  logic                      CPU_CLK,
    input  logic                      RESET,
    input  logic                      CPU_AS,
    input  logic                      UDS,
    input  logic                      LDS,
    input  logic                      RW,
    input  logic [23:1]               ADDRESS,
    input  logic [3:0]                DATA_IN,
    output logic [3:0]                AC_DATA_OUT,
    output logic                      AC_DATA_OE,
    output logic                      AC_DTACK,
    output logic                      AC_OPEN,
    output logic [8*NUM_BOARDS-1:0]   BOARD_BASE,
    output logic [NUM_BOARDS-1:0]     BOARD_CONFIGURED,
    output logic [NUM_BOARDS-1:0]     BOARD_SHUTUP,
    output logic [NUM_BOARDS-1:0]     BOARD_MATCH
);

    if (NUM_BOARDS < 1 || NUM_BOARDS > 4) begin : g_bad_num_boards
        $error("autoconfig_chain: NUM_BOARDS must be 1..4");
    end
    if (DTACK_WAIT < 1 || DTACK_WAIT > 7) begin : g_bad_dtack_wait
        $error("autoconfig_chain: DTACK_WAIT must be 1..7");
    end

    logic [NUM_BOARDS-1:0][7:0] base_q;
    logic [NUM_BOARDS-1:0]      configured_q;
    logic [NUM_BOARDS-1:0]      shutup_q;
    logic [3:0]                 data_q;
    logic                       ds_q;
    dtack_state_t               state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;

    logic       ds;
    logic       ds_fall;
    logic [1:0] active_idx;
    logic       active_valid;
    logic       ac_range;
    logic       wr_commit;
    logic       reread_hit;
    logic       ack_start;
    logic [3:0] rom_nibble;

    // A[15:8] play no part in AutoConfig decode (registers are mirrored).
    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDRESS[15:8];

    // ------------------------------------------------------------------
    // Active board: lowest index neither configured nor shut up. Scanning
    // downward lets the lowest qualifying index overwrite the others.
    // ------------------------------------------------------------------
    always_comb begin
        active_idx   = 2'd0;
        active_valid = 1'b0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (!configured_q[i] && !shutup_q[i]) begin
                active_idx   = 2'(i);
                active_valid = 1'b1;
            end
        end
    end

    assign AC_OPEN  = active_valid;
    assign ac_range = (ADDRESS[23:16] == AC_SPACE) && active_valid && !CPU_AS;

    // A strobe counts as asserted when either data strobe is low.
    assign ds      = UDS & LDS;
    assign ds_fall = ds_q && !ds;

    // One commit per strobe: only the falling edge of DS writes, however
    // long the CPU holds DS low.
    assign wr_commit = ds_fall && ac_range && !RW;

`ifdef AUTOCONFIG_REREAD_EN
    localparam logic [6:0] REREAD_OFS = 7'h3F;  // $7E
    localparam logic [3:0] REREAD_KEY = 4'hA;

    // Decoded without AC_OPEN so it still works once the chain has closed.
    assign reread_hit = ds_fall && !CPU_AS && !RW &&
                        (ADDRESS[23:16] == AC_SPACE) &&
                        (ADDRESS[7:1] == REREAD_OFS) &&
                        (DATA_IN == REREAD_KEY);
`else
    assign reread_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    acfg_nibble_rom #(
        .NUM_BOARDS   (NUM_BOARDS),
        .ER_TYPE      (ER_TYPE),
        .ER_PRODUCT   (ER_PRODUCT),
        .ER_FLAGS     (ER_FLAGS),
        .MANUFACTURER (MANUFACTURER),
        .SERIAL       (SERIAL)
    ) u_rom (
        .board_sel (active_idx),
        .index     (ADDRESS[7:1]),
        .nibble    (rom_nibble)
    );

    assign AC_DATA_OUT = data_q;
    assign AC_DATA_OE  = ac_range && RW;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge CPU_CLK or negedge RESET) begin
        if (!RESET) begin
            data_q <= 4'hF;
            ds_q   <= 1'b1;
        end else begin
            data_q <= rom_nibble;
            ds_q   <= ds;
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    // NOTE: the base table is a handful of flops, not a RAM, so it is reset
    // with everything else and downstream decode never sees X.
    always_ff @(posedge CPU_CLK or negedge RESET) begin
        if (!RESET) begin
            base_q       <= '0;
            configured_q <= '0;
            shutup_q     <= '0;
        end else if (reread_hit) begin
            configured_q <= '0;
            shutup_q     <= '0;
        end else if (wr_commit) begin
            case (ADDRESS[7:1])
                BASE_LO_OFS: base_q[active_idx][3:0] <= DATA_IN;
                BASE_HI_OFS: begin
                    base_q[active_idx][7:4]  <= DATA_IN;
                    configured_q[active_idx] <= 1'b1;
                end
                SHUTUP_OFS:  shutup_q[active_idx] <= 1'b1;
                default: ;
            endcase
        end
    end

    assign BOARD_BASE       = base_q;
    assign BOARD_CONFIGURED = configured_q;
    assign BOARD_SHUTUP     = shutup_q;

    // ------------------------------------------------------------------
    // /DTACK sequencer. Once started it ignores AC_OPEN, so the cycle that
    // closes the chain is still acknowledged.
    // ------------------------------------------------------------------
    assign ack_start = ds_fall && (ac_range || reread_hit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DT_IDLE: begin
                if (ack_start) begin
                    state_d = DT_WAIT;
                    cnt_d   = 3'(DTACK_WAIT - 1);
                end
            end
            DT_WAIT: begin
                if (CPU_AS)
                    state_d = DT_IDLE;  // CPU abandoned the cycle
                else if (cnt_q == 3'd0)
                    state_d = DT_ACK;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            DT_ACK: begin
                if (CPU_AS)
                    state_d = DT_IDLE;
            end
            default: state_d = DT_IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= DT_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gated with /AS so /DTACK releases in the same cycle /AS rises.
    assign AC_DTACK = !((state_q == DT_ACK) && !CPU_AS);

    // ------------------------------------------------------------------
    // Per-board window decode for the chip-select logic
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BOARDS; g++) begin : g_match
        localparam logic [7:0] MASK = size_mask(ER_TYPE[8*(NUM_BOARDS-1-g) +: 3]);
        assign BOARD_MATCH[g] = configured_q[g] && !CPU_AS &&
                                ((ADDRESS[23:16] & MASK) == (base_q[g] & MASK));
    end

endmodule

// File: tb/tb_autoconfig_chain.sv
// tb_autoconfig_chain: directed self-checking bench for autoconfig_chain with
// default parameters. Read data goes through a scoreboard queue: the expected
// nibble is pushed when the read is driven and popped when the registered
// output is valid. Configuration state is tracked in a small bench model.
module tb_autoconfig_chain;

    localparam int DTACK_WAIT = 2;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        cpu_as;
    logic        uds;
    logic        lds;
    logic        rw;
    logic [23:1] address;
    logic [3:0]  data_in;
    logic [3:0]  ac_data_out;
    logic        ac_data_oe;
    logic        ac_dtack;
    logic        ac_open;
    logic [23:0] board_base;
    logic [2:0]  board_configured;
    logic [2:0]  board_shutup;
    logic [2:0]  board_match;

    int total = 0;
    int bad   = 0;

    logic [3:0]  exp_q[$];
    logic [23:0] m_base;
    logic [2:0]  m_cfg;
    logic [2:0]  m_shut;

    always #5 cpu_clk = ~cpu_clk;

    autoconfig_chain #(.DTACK_WAIT(DTACK_WAIT)) dut (
        .CPU_CLK          (cpu_clk),
        .RESET            (reset),
        .CPU_AS           (cpu_as),
        .UDS              (uds),
        .LDS              (lds),
        .RW               (rw),
        .ADDRESS          (address),
        .DATA_IN          (data_in),
        .AC_DATA_OUT      (ac_data_out),
        .AC_DATA_OE       (ac_data_oe),
        .AC_DTACK         (ac_dtack),
        .AC_OPEN          (ac_open),
        .BOARD_BASE       (board_base),
        .BOARD_CONFIGURED (board_configured),
        .BOARD_SHUTUP     (board_shutup),
        .BOARD_MATCH      (board_match)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_base"}, board_base, m_base);
        check({tag, "_cfg"}, board_configured, m_cfg);
        check({tag, "_shut"}, board_shutup, m_shut);
        check({tag, "_open"}, ac_open, (~(m_cfg | m_shut)) != 3'b000);
    endtask

    task automatic bus_idle();
        cpu_as = 1'b1; uds = 1'b1; lds = 1'b1; rw = 1'b1;
    endtask

    // Bounded wait for /DTACK. Latency counts one edge to sample the strobe
    // plus DTACK_WAIT edges of programmed wait.
    task automatic wait_dtack(input string tag);
        int   n   = 0;
        logic got = 1'b0;
        while (!got && n < 20) begin
            @(negedge cpu_clk);
            n++;
            if (ac_dtack == 1'b0) got = 1'b1;
        end
        check({tag, "_ack"}, got, 1'b1);
        check({tag, "_lat"}, n, DTACK_WAIT + 1);
    endtask

    task automatic release_bus(input string tag, input int hold);
        repeat (hold) @(negedge cpu_clk);
        check({tag, "_held"}, ac_dtack, 1'b0);
        bus_idle();
        #1;
        check({tag, "_rel"}, ac_dtack, 1'b1);
        @(negedge cpu_clk);
    endtask

    task automatic ac_read(input logic [23:0] a, input logic [3:0] exp, input string tag);
        @(negedge cpu_clk);
        address = a[23:1]; rw = 1'b1; cpu_as = 1'b0;
        exp_q.push_back(exp);
        @(negedge cpu_clk);
        check({tag, "_oe"}, ac_data_oe, 1'b1);
        if (exp_q.size() != 0) check(tag, ac_data_out, exp_q.pop_front());
        uds = 1'b0; lds = 1'b0;
        wait_dtack(tag);
        release_bus(tag, 0);
    endtask

    task automatic ac_write(input logic [23:0] a, input logic [3:0] d, input int hold,
                            input string tag);
        @(negedge cpu_clk);
        address = a[23:1]; rw = 1'b0; data_in = d; cpu_as = 1'b0;
        @(negedge cpu_clk);
        uds = 1'b0; lds = 1'b0;
        wait_dtack(tag);
        release_bus(tag, hold);
    endtask

    task automatic probe_match(input logic [23:0] a, input logic as_n, input logic [2:0] exp,
                               input string tag);
        @(negedge cpu_clk);
        address = a[23:1]; rw = 1'b1; cpu_as = as_n;
        #1;
        check(tag, board_match, exp);
        bus_idle();
    endtask

    initial begin
        bus_idle();
        address = '0; data_in = 4'h0;
        m_base = '0; m_cfg = '0; m_shut = '0;

        // Reset values
        reset = 1'b0;
        #12;
        check_state("rst");
        check("rst_dout", ac_data_out, 4'hF);
        check("rst_oe", ac_data_oe, 1'b0);
        check("rst_dtack", ac_dtack, 1'b1);
        repeat (2) @(negedge cpu_clk);
        reset = 1'b1;

        // Board 0 (type E5, product 9F) register reads
        ac_read(24'hE80000, 4'hE, "b0_type_hi");
        ac_read(24'hE80002, 4'h5, "b0_type_lo");
        ac_read(24'hE80004, 4'h6, "b0_prod_hi");
        ac_read(24'hE80006, 4'h0, "b0_prod_lo");
        ac_read(24'hE80008, 4'h7, "b0_flags_hi");
        ac_read(24'hE8000C, 4'hF, "b0_undef_0c");
        ac_read(24'hE80012, 4'h8, "b0_mfr_lo");
        ac_read(24'hE80014, 4'h2, "b0_mfr2_hi");
        ac_read(24'hE8001E, 4'h5, "b0_ser1_lo");
        ac_read(24'hE80024, 4'h3, "b0_ser3_hi");
        ac_read(24'hE80028, 4'hF, "b0_undef_28");

        // Write to an unused offset changes nothing
        ac_write(24'hE80040, 4'h5, 0, "wr_ignored");
        check_state("after_ignored");

        // Configure board 0 at $200000; DS held low 6 extra cycles on $48
        ac_write(24'hE8004A, 4'h0, 0, "b0_base_lo");
        ac_write(24'hE80048, 4'h2, 6, "b0_base_hi");
        m_base[7:0] = 8'h20; m_cfg[0] = 1'b1;
        check_state("b0_cfg");

        // Board 1 (C4, 9E) is now presented
        ac_read(24'hE80000, 4'hC, "b1_type_hi");
        ac_read(24'hE80002, 4'h4, "b1_type_lo");
        ac_read(24'hE80006, 4'h1, "b1_prod_lo");

        // Board 0: 1 MB window $200000..$2FFFFF
        probe_match(24'h2FFFFE, 1'b0, 3'b001, "m_2ffffe");
        probe_match(24'h200000, 1'b0, 3'b001, "m_200000");
        probe_match(24'h300000, 1'b0, 3'b000, "m_300000");
        probe_match(24'h1FFFFE, 1'b0, 3'b000, "m_1ffffe");
        probe_match(24'h2FFFFE, 1'b1, 3'b000, "m_as_high");

        // Shut up board 1; board 2 (C1, 9D) becomes active
        ac_write(24'hE8004C, 4'h0, 0, "b1_shutup");
        m_shut[1] = 1'b1;
        check_state("b1_shut");
        ac_read(24'hE80002, 4'h1, "b2_type_lo");
        ac_read(24'hE80006, 4'h2, "b2_prod_lo");

        // Configure board 2 at $A40000 (64 KB); the chain closes but the
        // closing cycle is still acknowledged
        ac_write(24'hE8004A, 4'h4, 0, "b2_base_lo");
        ac_write(24'hE80048, 4'hA, 0, "b2_base_hi");
        m_base[23:16] = 8'hA4; m_cfg[2] = 1'b1;
        check_state("b2_cfg");

        // Closed chain: no data drive, no /DTACK
        @(negedge cpu_clk);
        address = 24'hE80000 >> 1; rw = 1'b1; cpu_as = 1'b0;
        #1;
        check("closed_oe", ac_data_oe, 1'b0);
        @(negedge cpu_clk);
        uds = 1'b0; lds = 1'b0;
        repeat (5) @(negedge cpu_clk);
        check("closed_dtack", ac_dtack, 1'b1);
        bus_idle();

        probe_match(24'hA4FFFE, 1'b0, 3'b100, "m_a4");
        probe_match(24'hA50000, 1'b0, 3'b000, "m_a5");
        probe_match(24'h2A0000, 1'b0, 3'b001, "m_2a");

`ifdef AUTOCONFIG_REREAD_EN
        ac_write(24'hE8007E, 4'hA, 0, "reread");
        m_cfg = '0; m_shut = '0;
        check_state("reread");
`else
        // Without re-enumeration the key write is not decoded at all
        @(negedge cpu_clk);
        address = 24'hE8007E >> 1; rw = 1'b0; data_in = 4'hA; cpu_as = 1'b0;
        @(negedge cpu_clk);
        uds = 1'b0; lds = 1'b0;
        repeat (5) @(negedge cpu_clk);
        check("noreread_dtack", ac_dtack, 1'b1);
        bus_idle();
        @(negedge cpu_clk);
        check_state("noreread");
`endif

        // Reset pulse clears the chain
        @(negedge cpu_clk);
        reset = 1'b0;
        #1;
        m_base = '0; m_cfg = '0; m_shut = '0;
        check_state("rst2");
        @(negedge cpu_clk);
        reset = 1'b1;

        // Configure board 0 at $430000, then reset in the middle of WAIT
        ac_write(24'hE8004A, 4'h3, 0, "r_base_lo");
        ac_write(24'hE80048, 4'h4, 0, "r_base_hi");
        m_base[7:0] = 8'h43; m_cfg[0] = 1'b1;
        check_state("r_cfg");

        @(negedge cpu_clk);
        address = 24'hE8004A >> 1; rw = 1'b0; data_in = 4'h1; cpu_as = 1'b0;
        @(negedge cpu_clk);
        uds = 1'b0; lds = 1'b0;
        @(posedge cpu_clk);
        #2;
        check("wait_dtack_high", ac_dtack, 1'b1);
        reset = 1'b0;
        #1;
        m_base = '0; m_cfg = '0; m_shut = '0;
        check_state("rst_wait");
        check("rst_wait_dtack", ac_dtack, 1'b1);
        check("rst_wait_dout", ac_data_out, 4'hF);
        bus_idle();
        @(negedge cpu_clk);
        reset = 1'b1;

        // Reset while /DTACK is asserted releases it at once, /AS still low
        @(negedge cpu_clk);
        address = 24'hE80000 >> 1; rw = 1'b1; cpu_as = 1'b0;
        @(negedge cpu_clk);
        uds = 1'b0; lds = 1'b0;
        wait_dtack("ack_rst");
        #2;
        reset = 1'b0;
        #1;
        check("rst_ack_dtack", ac_dtack, 1'b1);
        bus_idle();
        @(negedge cpu_clk);
        reset = 1'b1;
        @(negedge cpu_clk);
        check_state("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
